// File: rtl/level_debouncer.sv
// Switch debouncer: multi-flop synchroniser, four-state stability FSM, registered
// clean level, and a saturating count of rejected bounces.
module level_debouncer #(
    parameter  int SYNC_STAGES     = 2,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sw_in,
    input  logic       clr_bounce,
    output logic       db_level,
    output logic [7:0] bounce_cnt
);

    // state  | meaning
    // ZERO   | level accepted low, watching for s=1
    // WAIT1  | s went high, counting stable-high cycles
    // ONE    | level accepted high, watching for s=0
    // WAIT0  | s went low, counting stable-low cycles
    typedef enum logic [1:0] {
        ST_ZERO  = 2'b00,
        ST_WAIT1 = 2'b01,
        ST_ONE   = 2'b11,
        ST_WAIT0 = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_level_q, db_level_d;
    logic [7:0]             bounce_q, bounce_d;
    logic                   s;
    logic                   abort;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sw_in};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort   = 1'b0;
        case (state_q)
            ST_ZERO: begin
                if (s) begin
                    state_d = ST_WAIT1;
                    cnt_d   = '0;
                end
            end
            ST_WAIT1: begin
                if (!s) begin
                    state_d = ST_ZERO;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ONE: begin
                if (!s) begin
                    state_d = ST_WAIT0;
                    cnt_d   = '0;
                end
            end
            ST_WAIT0: begin
                if (s) begin
                    state_d = ST_ONE;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_ZERO;
                cnt_d   = '0;
            end
        endcase

        // Output flop is loaded from the next state so it moves on the same edge as the FSM.
        db_level_d = (state_d == ST_ONE) || (state_d == ST_WAIT0);

        bounce_d = bounce_q;
        if (clr_bounce) begin
            bounce_d = 8'h00;
        end else if (abort && (bounce_q != 8'hFF)) begin
            bounce_d = bounce_q + 8'h01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            state_q    <= ST_ZERO;
            cnt_q      <= '0;
            db_level_q <= 1'b0;
            bounce_q   <= 8'h00;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            db_level_q <= db_level_d;
            bounce_q   <= bounce_d;
        end
    end

    assign db_level   = db_level_q;
    assign bounce_cnt = bounce_q;

endmodule

// File: tb/tb_level_debouncer.sv
// Bench for level_debouncer: run-length reference model feeding a scoreboard queue,
// checked every cycle by an independent monitor, plus directed latency/saturation checks.
module tb_level_debouncer;

    localparam int SYNC = 2;
    localparam int DB   = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sw_in = 1'b0;
    logic       clr_bounce = 1'b0;
    logic       db_level;
    logic [7:0] bounce_cnt;

    level_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_in      (sw_in),
        .clr_bounce (clr_bounce),
        .db_level   (db_level),
        .bounce_cnt (bounce_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lvl;
        logic [7:0] bc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference: level flips once s has disagreed with it for DB+1 consecutive edges;
    // a disagreeing run that ends early is one rejected bounce.
    logic m_hist[$];
    logic m_level;
    int   m_run;
    int   m_bounce;

    function automatic void model_reset();
        m_hist = {};
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
        m_level  = 1'b0;
        m_run    = 0;
        m_bounce = 0;
    endfunction

    function automatic void model_edge(input logic sw, input logic clr);
        logic s;
        bit   aborted;
        aborted = 1'b0;
        s = m_hist.pop_front();
        m_hist.push_back(sw);
        if (s != m_level) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_level = ~m_level;
                m_run   = 0;
            end
        end else begin
            if (m_run > 0) aborted = 1'b1;
            m_run = 0;
        end
        if (clr) m_bounce = 0;
        else if (aborted && m_bounce < 255) m_bounce++;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Drive inputs for the next posedge and queue the model's prediction for it.
    task automatic step(input logic rst, input logic sw, input logic clr);
        exp_t e;
        @(negedge clk);
        reset_n    = rst;
        sw_in      = sw;
        clr_bounce = clr;
        if (rst) model_edge(sw, clr);
        else     model_reset();
        e.lvl = m_level;
        e.bc  = m_bounce[7:0];
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a registered output; compare against the queue.
    exp_t mon_e;
    logic prev_db = 1'b0;
    bit   count_en = 1'b0;
    int   rises = 0;
    int   falls = 0;

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_db_level", int'(db_level), int'(mon_e.lvl));
            chk("sb_bounce_cnt", int'(bounce_cnt), int'(mon_e.bc));
        end
        if (count_en && db_level && !prev_db) rises++;
        if (count_en && !db_level && prev_db) falls++;
        prev_db = db_level;
    end

    initial begin
        int len;
        logic lvl;
        model_reset();

        // 1. Reset held with sw_in high.
        repeat (10) step(1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b0);

        // 2. Clean press: edge 0 is the first high sample; rise after edge 6.
        repeat (6) step(1'b1, 1'b1, 1'b0);
        @(posedge clk); #2;
        chk("press_before_edge6", int'(db_level), 0);
        step(1'b1, 1'b1, 1'b0);
        @(posedge clk); #2;
        chk("press_after_edge6", int'(db_level), 1);
        repeat (4) step(1'b1, 1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("release_before_edge6", int'(db_level), 1);
        step(1'b1, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("release_after_edge6", int'(db_level), 0);
        repeat (4) step(1'b1, 1'b0, 1'b0);

        // 3. Bounce reject: 1,1,0 then a steady run of seven highs.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b1, 1'b1, 1'b0);
        @(posedge clk); #2;
        chk("bounce_rise_early", int'(db_level), 0);
        step(1'b1, 1'b1, 1'b0);
        @(posedge clk); #2;
        chk("bounce_rise", int'(db_level), 1);
        chk("bounce_cnt_one", int'(bounce_cnt), 1);

        // 4. Short glitch from a settled low level.
        repeat (10) step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        repeat (8) step(1'b1, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("glitch_level", int'(db_level), 0);
        chk("glitch_bounce", int'(bounce_cnt), 2);

        // 5. Saturation, then clear colliding with an abort.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, 1'b0);
            repeat (3) step(1'b1, 1'b0, 1'b0);
        end
        @(posedge clk); #2;
        chk("saturated", int'(bounce_cnt), 255);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        @(posedge clk); #2;
        chk("clear_wins", int'(bounce_cnt), 0);
        repeat (4) step(1'b1, 1'b0, 1'b0);

        // 6. Five glitches then steady: exactly one accepted rising level.
        count_en = 1'b1;
        for (int g = 0; g < 5; g++) begin
            repeat ($urandom_range(1, DB)) step(1'b1, 1'b1, 1'b0);
            repeat ($urandom_range(1, 3)) step(1'b1, 1'b0, 1'b0);
        end
        repeat (12) step(1'b1, 1'b1, 1'b0);
        @(posedge clk); #2;
        count_en = 1'b0;
        chk("integ_rises", rises, 1);
        chk("integ_falls", falls, 0);
        chk("integ_bounces", int'(bounce_cnt), 5);

        // Async reset in WAIT0 (db_level still high), no clock edge needed.
        repeat (4) step(1'b1, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("wait0_level_pre", int'(db_level), 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_level", int'(db_level), 0);
        chk("async_rst_bounce", int'(bounce_cnt), 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);

        // Async reset mid-WAIT1, then verify it returned to ZERO (full latency needed again).
        repeat (4) step(1'b1, 1'b1, 1'b0);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_wait1_level", int'(db_level), 0);
        step(1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b1, 1'b0);
        @(posedge clk); #2;
        chk("post_rst_restart", int'(db_level), 0);
        step(1'b1, 1'b1, 1'b0);
        @(posedge clk); #2;
        chk("post_rst_rise", int'(db_level), 1);

        // Randomised bouncing with occasional clears.
        for (int i = 0; i < 300; i++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++)
                step(1'b1, lvl, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        step(1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
